// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one pipelined signed/unsigned multiplier with optional >>WIDTH scaling.
// Optional round-half-up on scaled results: define MULT_SHARE_ROUND_EN.
module mult_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int PIPE  = 2,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                     Clk,
   input  logic                     nReset,
   input  logic [N_REQ-1:0]         Req,
   output logic [N_REQ-1:0]         Ack,
   input  logic [N_REQ*WIDTH-1:0]   OpA,
   input  logic [N_REQ*WIDTH-1:0]   OpB,
   input  logic [N_REQ*2-1:0]       Mode,
   input  logic [N_REQ-1:0]         Scale,
   output logic [2*WIDTH-1:0]       Result,
   output logic                     ResultValid,
   output logic [ID_W-1:0]          ResultId,
   output logic                     Busy
);

   localparam int PW = 2 * WIDTH;
   localparam int LAST = PIPE - 1;
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return ID_W'(sum);
   endfunction

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic [N_REQ-1:0] cand;

   // A requester just acknowledged sits out one decision, so no back-to-back double grant.
   assign cand = Req & ~Ack;

   // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && cand[wrap_inc(ptr, i)]) begin
            found  = 1'b1;
            winner = wrap_inc(ptr, i);
         end
      end
   end

   logic             iss_valid;
   logic [WIDTH-1:0] iss_a, iss_b;
   logic [1:0]       iss_mode;
   logic             iss_scale;
   logic [ID_W-1:0]  iss_id;

   // NOTE: sequential state always uses non-blocking assignments.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         ptr       <= '0;
         Ack       <= '0;
         iss_valid <= 1'b0;
      end else begin
         iss_valid <= found;
         Ack       <= found ? (ONE << winner) : '0;
         if (found) ptr <= wrap_inc(winner, 1);
      end
   end

   // NOTE: datapath registers carry no reset; only the valid bits qualify them.
   always_ff @(posedge Clk) begin
      if (found) begin
         iss_a     <= OpA[winner*WIDTH +: WIDTH];
         iss_b     <= OpB[winner*WIDTH +: WIDTH];
         iss_mode  <= Mode[winner*2 +: 2];
         iss_scale <= Scale[winner];
         iss_id    <= winner;
      end
   end

   // One extra bit per operand makes a single signed multiply exact for all sign modes.
   logic signed [WIDTH:0]   ext_a, ext_b;
   logic signed [PW+1:0]    prod_full;
   logic [PW-1:0]           prod;
   logic                    unused_prod_hi;

   assign ext_a          = $signed({iss_mode[0] & iss_a[WIDTH-1], iss_a});
   assign ext_b          = $signed({iss_mode[1] & iss_b[WIDTH-1], iss_b});
   assign prod_full      = ext_a * ext_b;
   assign prod           = prod_full[PW-1:0];
   assign unused_prod_hi = ^prod_full[PW+1:PW];

   logic            stg_valid [PIPE];
   logic [PW-1:0]   stg_prod  [PIPE];
   logic            stg_scale [PIPE];
   logic            stg_sgn   [PIPE];
   logic [ID_W-1:0] stg_id    [PIPE];

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         for (int k = 0; k < PIPE; k++) stg_valid[k] <= 1'b0;
      end else begin
         stg_valid[0] <= iss_valid;
         for (int k = 1; k < PIPE; k++) stg_valid[k] <= stg_valid[k-1];
      end
   end

   always_ff @(posedge Clk) begin
      stg_prod[0]  <= prod;
      stg_scale[0] <= iss_scale;
      stg_sgn[0]   <= |iss_mode;
      stg_id[0]    <= iss_id;
      for (int k = 1; k < PIPE; k++) begin
         stg_prod[k]  <= stg_prod[k-1];
         stg_scale[k] <= stg_scale[k-1];
         stg_sgn[k]   <= stg_sgn[k-1];
         stg_id[k]    <= stg_id[k-1];
      end
   end

   always_comb begin
      Busy = iss_valid;
      for (int k = 0; k < PIPE; k++) Busy = Busy | stg_valid[k];
   end

   logic [PW-1:0] fin_prod, fin_res;
   logic          fill;

`ifdef MULT_SHARE_ROUND_EN
   localparam logic [PW-1:0] HALF_LSB = PW'(1) << (WIDTH - 1);
   assign fin_prod = stg_scale[LAST] ? stg_prod[LAST] + HALF_LSB : stg_prod[LAST];
`else
   assign fin_prod = stg_prod[LAST];
`endif

   assign fill    = stg_sgn[LAST] & fin_prod[PW-1];
   assign fin_res = stg_scale[LAST] ? {{WIDTH{fill}}, fin_prod[PW-1 -: WIDTH]} : fin_prod;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Result      <= '0;
         ResultValid <= 1'b0;
         ResultId    <= '0;
      end else begin
         ResultValid <= stg_valid[LAST];
         if (stg_valid[LAST]) begin
            Result   <= fin_res;
            ResultId <= stg_id[LAST];
         end
      end
   end

endmodule
